// File: rtl/pc_gen_ysyx_if.sv
// Fetch-side bus between the next-PC generator and the rest of the core:
// decoder operands, commit/redirect controls, and the IFU valid/ready pair.
`timescale 1ns/1ps
interface pc_gen_ysyx_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
);
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  rs1;
   logic             PCAsrc;
   logic             PCBsrc;
   logic             commit_valid;
   logic             trap_valid;
   logic [XLEN-1:0]  mtvec;
   logic             mret_valid;
   logic [XLEN-1:0]  mepc;
   logic [XLEN-1:0]  pc;
   logic             pc_valid;
   logic             pc_ready;
   logic             misalign;
   logic [CNT_W-1:0] instret;

   // PC generator side: drives the fetch address and status.
   modport master (
      output pc, pc_valid, misalign, instret,
      input  imm, rs1, PCAsrc, PCBsrc, commit_valid, trap_valid,
             mtvec, mret_valid, mepc, pc_ready
   );

   // Core/IFU side: supplies operands, commits and the ready.
   modport slave (
      input  pc, pc_valid, misalign, instret,
      output imm, rs1, PCAsrc, PCBsrc, commit_valid, trap_valid,
             mtvec, mret_valid, mepc, pc_ready
   );
endinterface

// File: rtl/pc_gen_ysyx.sv
// Sequential next-PC generator: holds the architectural PC, offers it to the
// IFU with valid/ready, and on retirement computes the next fetch address
// (A+B adder with JALR LSB clear, trap/mret redirects, misalignment trap)
// while counting retired instructions.
`timescale 1ns/1ps
module pc_gen_ysyx #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h80000000,
   parameter int              CNT_W     = 64
) (
   input  logic           clk,
   input  logic           rst,
   pc_gen_ysyx_if.master  bus
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             w_pcValid;
   logic             w_commit;

   logic [XLEN-1:0]  r_pc;
   logic             r_misalign;
   logic [CNT_W-1:0] r_instret;

   logic [XLEN-1:0]  w_addA;
   logic [XLEN-1:0]  w_addB;
   logic [XLEN-1:0]  w_sum;
   logic             w_isJalr;
   logic [XLEN-1:0]  w_target;
   logic             w_badTarget;
   logic [XLEN-1:0]  w_nextPc;

   // State register; reset drops back to the BOOT bubble immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= BOOT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode; pc_valid is a pure function of the state, and
   // commits are only honoured while waiting for the instruction to retire.
   always_comb begin
      w_nextState = r_state;
      w_pcValid   = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         BOOT: begin
            w_nextState = FETCH;
         end
         FETCH: begin
            w_pcValid = 1'b1;
            if (bus.pc_ready) begin
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            if (bus.commit_valid) begin
               w_commit    = 1'b1;
               w_nextState = FETCH;
            end
         end
         default: begin
            w_nextState = BOOT;
         end
      endcase
   end

   // Target adder and redirect selection; JALR clears bit 0 before the
   // alignment check, and only the computed target is alignment-checked.
   always_comb begin
      w_addA      = bus.PCAsrc ? bus.imm : XLEN'(32'd4);
      w_addB      = bus.PCBsrc ? r_pc : bus.rs1;
      w_sum       = w_addA + w_addB;
      w_isJalr    = bus.PCAsrc & ~bus.PCBsrc;
      w_target    = {w_sum[XLEN-1:1], w_sum[0] & ~w_isJalr};
      w_badTarget = ~bus.trap_valid & ~bus.mret_valid & (|w_target[1:0]);
      if (bus.trap_valid) begin
         w_nextPc = bus.mtvec;
      end else if (bus.mret_valid) begin
         w_nextPc = bus.mepc;
      end else if (w_badTarget) begin
         w_nextPc = bus.mtvec;
      end else begin
         w_nextPc = w_target;
      end
   end

   // Architectural PC, misalignment pulse and retire counter all move only
   // on an accepted commit; the pulse self-clears on the following edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= RESET_VEC;
         r_misalign <= 1'b0;
         r_instret  <= '0;
      end else if (w_commit) begin
         r_pc       <= w_nextPc;
         r_misalign <= w_badTarget;
         r_instret  <= r_instret + CNT_W'(1);
      end else begin
         r_misalign <= 1'b0;
      end
   end

   assign bus.pc       = r_pc;
   assign bus.pc_valid = w_pcValid;
   assign bus.misalign = r_misalign;
   assign bus.instret  = r_instret;

endmodule

// File: tb/tb_pc_gen_ysyx.sv
// Directed bench for pc_gen_ysyx: a table of fetch/commit vectors with
// hand-computed next-PC values, plus hand-written boot, stall and
// asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_pc_gen_ysyx;

   localparam logic [31:0] RESET_PC = 32'h80000000;

   logic clk;
   logic rst;

   int compared;
   int mismatched;

   pc_gen_ysyx_if #(.XLEN(32), .CNT_W(64)) bus ();

   pc_gen_ysyx #(
      .XLEN      (32),
      .RESET_VEC (32'h80000000),
      .CNT_W     (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic        pcA;
      logic        pcB;
      logic        trap;
      logic        mret;
      logic [31:0] mtvec;
      logic [31:0] mepc;
      logic [31:0] expPc;
      logic        expMisalign;
      logic [63:0] expInstret;
   } vec_t;

   vec_t vecs [14];

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, reports a FAIL line on a difference.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Default values for all driven inputs.
   task automatic applyStimulus(input logic [31:0] imm, input logic [31:0] rs1,
                                input logic pcA, input logic pcB,
                                input logic trap, input logic mret,
                                input logic [31:0] mtvec, input logic [31:0] mepc,
                                input logic commit);
      bus.imm          = imm;
      bus.rs1          = rs1;
      bus.PCAsrc       = pcA;
      bus.PCBsrc       = pcB;
      bus.trap_valid   = trap;
      bus.mret_valid   = mret;
      bus.mtvec        = mtvec;
      bus.mepc         = mepc;
      bus.commit_valid = commit;
   endtask

   // Release reset at a falling edge and check the single BOOT bubble.
   task automatic bootSequence(input string tag);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput({tag, "_boot_pc"}, 64'(bus.pc), 64'(RESET_PC));
      checkOutput({tag, "_boot_valid0"}, 64'(bus.pc_valid), 64'd0);
      checkOutput({tag, "_boot_instret"}, bus.instret, 64'd0);
      checkOutput({tag, "_boot_misalign"}, 64'(bus.misalign), 64'd0);
      tick();
      checkOutput({tag, "_boot_valid1"}, 64'(bus.pc_valid), 64'd1);
      checkOutput({tag, "_boot_pc_hold"}, 64'(bus.pc), 64'(RESET_PC));
   endtask

   // One full instruction: handshake cycle in FETCH, commit cycle in WAIT.
   task automatic runInstr(input vec_t v, input logic [31:0] curPc);
      checkOutput({v.name, "_offer_valid"}, 64'(bus.pc_valid), 64'd1);
      checkOutput({v.name, "_offer_pc"}, 64'(bus.pc), 64'(curPc));
      bus.pc_ready = 1'b1;
      tick();
      bus.pc_ready = 1'b0;
      checkOutput({v.name, "_wait_valid"}, 64'(bus.pc_valid), 64'd0);
      checkOutput({v.name, "_wait_misalign"}, 64'(bus.misalign), 64'd0);
      checkOutput({v.name, "_wait_pc"}, 64'(bus.pc), 64'(curPc));
      applyStimulus(v.imm, v.rs1, v.pcA, v.pcB, v.trap, v.mret, v.mtvec, v.mepc, 1'b1);
      tick();
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput({v.name, "_pc"}, 64'(bus.pc), 64'(v.expPc));
      checkOutput({v.name, "_misalign"}, 64'(bus.misalign), 64'(v.expMisalign));
      checkOutput({v.name, "_instret"}, bus.instret, v.expInstret);
      checkOutput({v.name, "_next_valid"}, 64'(bus.pc_valid), 64'd1);
   endtask

   initial begin
      logic [31:0] curPc;
      vec_t        extra;

      compared   = 0;
      mismatched = 0;

      //                 name         imm           rs1           A     B     trap  mret  mtvec         mepc          expPc         mis   instret
      vecs[0]  = '{"seq1",      32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h80000004, 1'b0, 64'd1};
      vecs[1]  = '{"seq2",      32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h80000008, 1'b0, 64'd2};
      vecs[2]  = '{"seq3",      32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h8000000C, 1'b0, 64'd3};
      vecs[3]  = '{"jal",       32'h10,       32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h8000001C, 1'b0, 64'd4};
      vecs[4]  = '{"jalr_mis",  32'h0,        32'h80001003, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000100, 32'h0,        32'h80000100, 1'b1, 64'd5};
      vecs[5]  = '{"trap_mret", 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h80000100, 32'h80000200, 32'h80000100, 1'b0, 64'd6};
      vecs[6]  = '{"mret",      32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h80000100, 32'h80000200, 32'h80000200, 1'b0, 64'd7};
      vecs[7]  = '{"jalr_clr",  32'h5,        32'h80000040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000100, 32'h0,        32'h80000044, 1'b0, 64'd8};
      vecs[8]  = '{"br_neg",    32'hFFFFFFF0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h80000100, 32'h0,        32'h80000034, 1'b0, 64'd9};
      vecs[9]  = '{"jal_mis",   32'h2,        32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h80000100, 32'h0,        32'h80000100, 1'b1, 64'd10};
      vecs[10] = '{"jalr_wrap", 32'h8,        32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000100, 32'h0,        32'h00000004, 1'b0, 64'd11};
      vecs[11] = '{"trap_over", 32'h2,        32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h80000300, 32'h0,        32'h80000300, 1'b0, 64'd12};
      vecs[12] = '{"mret_odd",  32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h80000300, 32'h80000402, 32'h80000402, 1'b0, 64'd13};
      vecs[13] = '{"seq_mis",   32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h80000040, 32'h0,        32'h80000040, 1'b1, 64'd14};

      // Power-on reset with a couple of clock edges under reset.
      rst          = 1'b1;
      bus.pc_ready = 1'b0;
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      checkOutput("rst_valid", 64'(bus.pc_valid), 64'd0);
      checkOutput("rst_pc", 64'(bus.pc), 64'(RESET_PC));
      bootSequence("por");

      // Table of fetch/commit vectors chained from the reset PC.
      curPc = RESET_PC;
      foreach (vecs[i]) begin
         runInstr(vecs[i], curPc);
         curPc = vecs[i].expPc;
      end

      // Stall in FETCH with pc_ready low while commits are (illegally) pulsed.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(32'h100, 32'h0, 1'b1, 1'b1, i[0], 1'b0, 32'h80000300, 32'h0, ~i[0]);
         tick();
         checkOutput($sformatf("stall%0d_valid", i), 64'(bus.pc_valid), 64'd1);
         checkOutput($sformatf("stall%0d_pc", i), 64'(bus.pc), 64'(32'h80000040));
         checkOutput($sformatf("stall%0d_instret", i), bus.instret, 64'd14);
      end
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      extra = '{"post_stall", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h80000044, 1'b0, 64'd15};
      runInstr(extra, 32'h80000040);
      extra = '{"back_40", 32'hFFFFFFFC, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h80000040, 1'b0, 64'd16};
      runInstr(extra, 32'h80000044);

      // Enter WAIT at pc=0x80000040 with a commit pending, then reset between edges.
      bus.pc_ready = 1'b1;
      tick();
      bus.pc_ready = 1'b0;
      checkOutput("areset_pre_valid", 64'(bus.pc_valid), 64'd0);
      checkOutput("areset_pre_pc", 64'(bus.pc), 64'(32'h80000040));
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("areset_pc", 64'(bus.pc), 64'(RESET_PC));
      checkOutput("areset_instret", bus.instret, 64'd0);
      checkOutput("areset_valid", 64'(bus.pc_valid), 64'd0);
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      bootSequence("areset");

      // One instruction after the reboot to show the counter restarted.
      extra = '{"reboot_seq", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h80000004, 1'b0, 64'd1};
      runInstr(extra, RESET_PC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pc_gen_ysyx.md
# pc_gen_ysyx

Sequential next-PC generator for the NPC core: holds the architectural PC in its own register, presents it to the IFU through a valid/ready handshake, and computes the next fetch address when the EXU reports that the instruction at the current PC has retired. It generalises the NPC's combinational A+B next-PC adder with parametrised width and reset vector, trap and mret redirects, JALR LSB clearing, misaligned-target detection and a retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, width of PC, imm, rs1, mtvec, mepc.
- RESET_VEC, 32'h80000000, PC value loaded on reset.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imm  in  XLEN  immediate from the decoder.
- rs1  in  XLEN  register-file source 1.
- PCAsrc  in  1  0: addend A = 4; 1: addend A = imm.
- PCBsrc  in  1  0: addend B = rs1 (JALR); 1: addend B = pc.
- commit_valid  in  1  the instruction at pc has retired this cycle.
- trap_valid  in  1  the retiring instruction traps; redirect to mtvec.
- mtvec  in  XLEN  trap vector.
- mret_valid  in  1  the retiring instruction is mret; redirect to mepc.
- mepc  in  XLEN  return address.
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  pc is offered to the IFU.
- pc_ready  in  1  the IFU accepts pc.
- misalign  out  1  one-cycle pulse: the computed target was not 4-byte aligned.
- instret  out  CNT_W  count of retired instructions.

## Operation
- FSM states: BOOT, FETCH, WAIT.
- BOOT: entered on reset; pc_valid=0; moves unconditionally to FETCH on the next edge (one bubble cycle after reset release).
- FETCH: pc_valid=1; on pc_valid&&pc_ready, go to WAIT. commit_valid, trap_valid and mret_valid are ignored in FETCH (protocol violation; no state change, no count).
- WAIT: pc_valid=0; pc is held. On commit_valid, load next pc, increment instret by 1 (wrapping modulo 2^CNT_W), and go to FETCH. Without commit_valid, stay in WAIT indefinitely.
- Next-pc priority on commit: trap_valid -> mtvec; else mret_valid -> mepc; else target.
- target = A + B, truncated to XLEN (overflow wraps). When PCAsrc=1 and PCBsrc=0 (JALR), bit 0 of the sum is cleared.
- Misalignment: if trap_valid=0, mret_valid=0, and target[1:0] != 0 after the LSB clear, the unit loads mtvec instead, and misalign pulses high for the cycle after the commit edge. trap_valid and mret_valid take precedence; neither mtvec nor mepc is alignment-checked.
- Trapping instructions still count in instret.
- Reset values: pc=RESET_VEC, pc_valid=0, misalign=0, instret=0, state=BOOT.
- Asserting rst in any state, including mid-handshake, immediately forces all reset values. A pending commit is lost.

## Timing
- pc, misalign and instret are registered. pc_valid is a pure decode of the state.
- Fetch handshake to next offer: handshake edge -> WAIT. The commit edge updates pc, and the new pc is offered with pc_valid=1 in the cycle immediately following.
- Minimum loop: 1 FETCH cycle (pc_ready=1) + 1 WAIT cycle (commit_valid=1) = 2 cycles per instruction.
- pc is stable whenever pc_valid=1 and until the handshake completes. pc_ready low holds the FETCH state and pc unchanged.
- Next-pc selection and the adder are combinational from the inputs sampled at the commit edge. There is no extra latency.

## Test plan
- Reset/boot: assert rst, then release. Required: pc=0x80000000, pc_valid=0 for exactly one cycle, then 1; instret=0.
- Sequential flow: pc_ready=1, commit with PCAsrc=0, PCBsrc=1, repeated 3 times. Required: pc steps 0x80000000 -> 0x80000004 -> 0x80000008 -> 0x8000000C, instret=3, and 2 cycles per step.
- JAL/JALR: imm=0x10, PCAsrc=1, PCBsrc=1 gives pc+0x10. rs1=0x80001003, imm=0, PCAsrc=1, PCBsrc=0 gives 0x80001002, which is misaligned, so pc=mtvec and misalign pulses for 1 cycle.
- Priority: commit with trap_valid=1, mret_valid=1, mtvec=0x80000100, mepc=0x80000200. Required: pc=0x80000100 and misalign=0. With mret_valid alone, required: pc=0x80000200.
- Handshake stall and ignored commit: hold pc_ready=0 for 5 cycles while pulsing commit_valid. Required: pc and instret unchanged and pc_valid held at 1. Then raise pc_ready and commit once. Required: instret increments by 1.
- Async reset mid-WAIT: assert rst between clock edges while in WAIT with pc=0x80000040. Required: pc=0x80000000 and instret=0 immediately, before the next clock edge; the BOOT sequence then repeats.
